// File: rtl/alu_iter_mdu.sv
// alu_iter_mdu: EX-stage integer unit. Single-cycle R-type ALU ops plus
// iterative (one bit per clock) multiply and restoring divide.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 synchronous abort of any in-flight op
//   in_valid/in_ready     request handshake; op_sel, rs1_data, rs2_data, in_tag
//   out_valid/out_ready   result handshake; rd_data, out_tag, illegal_op
//   busy                  unit is not idle
module alu_iter_mdu #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned TAGW = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      op_sel,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rd_data,
   output logic [TAGW-1:0] out_tag,
   output logic            illegal_op,
   output logic            busy
);

   localparam int unsigned SW = $clog2(XLEN);
   localparam int unsigned PW = 2 * XLEN;

   localparam logic [4:0] OP_ADD   = 5'b00000;
   localparam logic [4:0] OP_SUB   = 5'b00001;
   localparam logic [4:0] OP_AND   = 5'b00010;
   localparam logic [4:0] OP_OR    = 5'b00011;
   localparam logic [4:0] OP_XOR   = 5'b00100;
   localparam logic [4:0] OP_SLL   = 5'b00101;
   localparam logic [4:0] OP_SRL   = 5'b00110;
   localparam logic [4:0] OP_SRA   = 5'b00111;
   localparam logic [4:0] OP_SLT   = 5'b01000;
   localparam logic [4:0] OP_SLTU  = 5'b01001;
   localparam logic [4:0] OP_MUL   = 5'b11001;
   localparam logic [4:0] OP_MULH  = 5'b11010;
   localparam logic [4:0] OP_MULHU = 5'b11011;
   localparam logic [4:0] OP_DIV   = 5'b11100;
   localparam logic [4:0] OP_DIVU  = 5'b11101;
   localparam logic [4:0] OP_REM   = 5'b11110;
   localparam logic [4:0] OP_REMU  = 5'b11111;

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   logic [SW-1:0]     cnt;
   logic [4:0]        op_q;
   logic              neg_q;
   logic [XLEN-1:0]   opnd_q;   // |A| for multiply, |B| (divisor) for divide
   logic [PW-1:0]     prod_q;   // mul: {acc, multiplier}; div: {remainder, dividend/quotient}

   // Request decode and single-cycle results
   logic              is_alu, is_mul, is_div, sgn_op, sa, sb, div_fast;
   logic [XLEN-1:0]   alu_res, fast_res, abs_a, abs_b;
   logic [SW-1:0]     sh;

   always_comb begin
      is_alu   = 1'b0;
      is_mul   = 1'b0;
      is_div   = 1'b0;
      alu_res  = '0;
      fast_res = '0;
      sh       = rs2_data[SW-1:0];
      case (op_sel)
         OP_ADD:  begin is_alu = 1'b1; alu_res = rs1_data + rs2_data; end
         OP_SUB:  begin is_alu = 1'b1; alu_res = rs1_data - rs2_data; end
         OP_AND:  begin is_alu = 1'b1; alu_res = rs1_data & rs2_data; end
         OP_OR:   begin is_alu = 1'b1; alu_res = rs1_data | rs2_data; end
         OP_XOR:  begin is_alu = 1'b1; alu_res = rs1_data ^ rs2_data; end
         OP_SLL:  begin is_alu = 1'b1; alu_res = rs1_data << sh; end
         OP_SRL:  begin is_alu = 1'b1; alu_res = rs1_data >> sh; end
         OP_SRA:  begin is_alu = 1'b1; alu_res = XLEN'($signed(rs1_data) >>> sh); end
         OP_SLT:  begin is_alu = 1'b1; alu_res = XLEN'($signed(rs1_data) < $signed(rs2_data)); end
         OP_SLTU: begin is_alu = 1'b1; alu_res = XLEN'(rs1_data < rs2_data); end
         OP_MUL, OP_MULH, OP_MULHU:        is_mul = 1'b1;
         OP_DIV, OP_DIVU, OP_REM, OP_REMU: is_div = 1'b1;
         default: ;
      endcase
      sgn_op = (op_sel == OP_MUL) || (op_sel == OP_MULH) ||
               (op_sel == OP_DIV) || (op_sel == OP_REM);
      sa     = sgn_op & rs1_data[XLEN-1];
      sb     = sgn_op & rs2_data[XLEN-1];
      abs_a  = sa ? -rs1_data : rs1_data;
      abs_b  = sb ? -rs2_data : rs2_data;
      // Divide by zero and signed overflow resolve without iterating
      div_fast = 1'b0;
      if (is_div && (rs2_data == '0)) begin
         div_fast = 1'b1;
         fast_res = op_sel[1] ? rs1_data : '1;
      end else if (is_div && sgn_op && (rs1_data == MOST_NEG) && (rs2_data == '1)) begin
         div_fast = 1'b1;
         fast_res = op_sel[1] ? '0 : MOST_NEG;
      end
   end

   // One iteration step of shift-add multiply or restoring divide
   logic [XLEN-1:0] addend;
   logic [XLEN:0]   mul_sum, rem_sh, div_trial;
   logic [PW-1:0]   prod_nx, prod_fin;
   logic [XLEN-1:0] quo, rem, fin_res;

   always_comb begin
      addend    = prod_q[0] ? opnd_q : '0;
      mul_sum   = {1'b0, prod_q[PW-1:XLEN]} + {1'b0, addend};
      rem_sh    = {prod_q[PW-1:XLEN], prod_q[XLEN-1]};
      div_trial = rem_sh - {1'b0, opnd_q};
      if (op_q[2]) begin
         if (div_trial[XLEN]) prod_nx = {rem_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
         else                 prod_nx = {div_trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
      end else begin
         prod_nx = {mul_sum, prod_q[XLEN-1:1]};
      end
      prod_fin = neg_q ? -prod_nx : prod_nx;
      quo      = prod_nx[XLEN-1:0];
      rem      = prod_nx[PW-1:XLEN];
      case (op_q)
         OP_MUL:           fin_res = prod_fin[XLEN-1:0];
         OP_MULH, OP_MULHU: fin_res = prod_fin[PW-1:XLEN];
         OP_DIV, OP_DIVU:  fin_res = neg_q ? -quo : quo;
         default:          fin_res = neg_q ? -rem : rem;
      endcase
   end

   // Control FSM with registered result, tag and illegal flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         op_q       <= '0;
         neg_q      <= 1'b0;
         opnd_q     <= '0;
         prod_q     <= '0;
         rd_data    <= '0;
         out_tag    <= '0;
         illegal_op <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               out_tag <= in_tag;
               op_q    <= op_sel;
               if ((is_mul || is_div) && !div_fast) begin
                  state      <= BUSY;
                  cnt        <= '0;
                  illegal_op <= 1'b0;
                  opnd_q     <= is_mul ? abs_a : abs_b;
                  prod_q     <= {{XLEN{1'b0}}, (is_mul ? abs_b : abs_a)};
                  // Remainder takes the dividend sign; everything else sA^sB
                  neg_q      <= (is_div && op_sel[1]) ? sa : (sa ^ sb);
               end else begin
                  state      <= DONE;
                  rd_data    <= is_alu ? alu_res : (is_div ? fast_res : '0);
                  illegal_op <= !(is_alu || is_mul || is_div);
               end
            end
            BUSY: begin
               prod_q <= prod_nx;
               if (cnt == SW'(XLEN - 1)) begin
                  state   <= DONE;
                  cnt     <= '0;
                  rd_data <= fin_res;
               end else begin
                  cnt <= cnt + SW'(1);
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = rst_n && (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_iter_mdu.sv
// Randomised scoreboard bench for alu_iter_mdu against an arithmetic reference model.
module tb_alu_iter_mdu;

   localparam logic [31:0] MIN32 = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [4:0]  op_sel, in_tag, out_tag;
   logic [31:0] rs1_data, rs2_data, rd_data;
   logic        illegal_op, busy;

   alu_iter_mdu #(.XLEN(32), .TAGW(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .rd_data(rd_data),
      .out_tag(out_tag), .illegal_op(illegal_op), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  tag;
      logic        ill;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model straight from the instruction definitions
   function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] d, output logic ill, output int lat);
      int          sa, sb;
      logic [63:0] ps, pu;
      sa = a; sb = b; d = '0; ill = 1'b0; lat = 1;
      case (op)
         5'b00000: d = a + b;
         5'b00001: d = a - b;
         5'b00010: d = a & b;
         5'b00011: d = a | b;
         5'b00100: d = a ^ b;
         5'b00101: d = a << b[4:0];
         5'b00110: d = a >> b[4:0];
         5'b00111: d = 32'(sa >>> b[4:0]);
         5'b01000: d = {31'b0, sa < sb};
         5'b01001: d = {31'b0, a < b};
         5'b11001: begin ps = 64'(longint'(sa) * longint'(sb)); d = ps[31:0]; lat = 33; end
         5'b11010: begin ps = 64'(longint'(sa) * longint'(sb)); d = ps[63:32]; lat = 33; end
         5'b11011: begin pu = {32'b0, a} * {32'b0, b}; d = pu[63:32]; lat = 33; end
         5'b11100: if (b == 0) d = '1;
                   else if (a == MIN32 && b == '1) d = MIN32;
                   else begin d = 32'(sa / sb); lat = 33; end
         5'b11101: if (b == 0) d = '1; else begin d = a / b; lat = 33; end
         5'b11110: if (b == 0) d = a;
                   else if (a == MIN32 && b == '1) d = '0;
                   else begin d = 32'(sa % sb); lat = 33; end
         5'b11111: if (b == 0) d = a; else begin d = a % b; lat = 33; end
         default:  ill = 1'b1;
      endcase
   endfunction

   task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input bit track);
      int   n = 0;
      exp_t e;
      int   lat;
      @(negedge clk);
      while (!in_ready && n < 300) begin @(negedge clk); n++; end
      if (!in_ready) begin
         chk("send_timeout", 64'(in_ready), 64'd1);
         return;
      end
      in_valid = 1'b1; op_sel = op; rs1_data = a; rs2_data = b; in_tag = tag;
      if (track) begin
         model(op, a, b, e.d, e.ill, lat);
         e.tag = tag;
         e.cyc = cyc + lat;
         q.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return MIN32;
         3: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   // out_ready driver, changed just after the rising edge
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops the scoreboard on each new result, checks hold while stalled
   initial begin : monitor
      bit          seen = 0;
      exp_t        e;
      logic [31:0] hd;
      logic [4:0]  ht;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 0;
         end else if (out_valid) begin
            if (!seen) begin
               if (q.size() == 0) begin
                  chk("unexpected_valid", 64'(out_valid), 64'd0);
               end else begin
                  e = q.pop_front();
                  chk("rd_data", 64'(rd_data), 64'(e.d));
                  chk("out_tag", 64'(out_tag), 64'(e.tag));
                  chk("illegal_op", 64'(illegal_op), 64'(e.ill));
                  chk("latency", 64'(cyc), 64'(e.cyc));
               end
               hd = rd_data; ht = out_tag; seen = 1;
            end else begin
               chk("hold_rd_data", 64'(rd_data), 64'(hd));
               chk("hold_out_tag", 64'(out_tag), 64'(ht));
               chk("hold_in_ready", 64'(in_ready), 64'd0);
            end
            if (out_ready) seen = 0;
         end
      end
   end

   initial begin : stimulus
      int n;
      bit saw_valid;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
      op_sel = '0; rs1_data = '0; rs2_data = '0; in_tag = '0;
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rd_data", 64'(rd_data), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_illegal", 64'(illegal_op), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd1);

      // Directed cases
      send(5'b00000, 32'h0000_0005, 32'hFFFF_FFFE, 5'd3, 1);
      send(5'b01001, 32'hFFFF_FFFF, 32'h0000_0001, 5'd4, 1);
      send(5'b11001, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 1);
      send(5'b11010, MIN32, MIN32, 5'd6, 1);
      send(5'b11011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1);
      send(5'b11100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8, 1);
      send(5'b11110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9, 1);
      send(5'b11101, 32'h0000_0005, 32'h0000_0000, 5'd10, 1);
      send(5'b11111, 32'h0000_0005, 32'h0000_0000, 5'd11, 1);
      send(5'b11100, MIN32, 32'hFFFF_FFFF, 5'd12, 1);
      send(5'b11110, MIN32, 32'hFFFF_FFFF, 5'd13, 1);
      send(5'b10101, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, 1);

      // Stall the consumer for 4 cycles, then release and go back-to-back
      rdy_mode = 1;
      send(5'b00001, 32'h0000_0010, 32'h0000_0001, 5'd15, 1);
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      chk("hold_valid_seen", 64'(out_valid), 64'd1);
      repeat (4) @(negedge clk);
      rdy_mode = 0;
      repeat (2) @(negedge clk);
      chk("release_in_ready", 64'(in_ready), 64'd1);
      send(5'b00000, 32'h0000_0001, 32'h0000_0002, 5'd7, 1);

      // Flush a divide on its 10th busy cycle
      n = 0;
      while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
      send(5'b11100, 32'h0000_1234, 32'h0000_0007, 5'd20, 0);
      repeat (10) @(negedge clk);
      chk("flush_busy_before", 64'(busy), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      saw_valid = 0;
      repeat (40) begin @(negedge clk); if (out_valid) saw_valid = 1; end
      chk("flush_no_valid", 64'(saw_valid), 64'd0);

      // Asynchronous reset in the middle of a multiply
      send(5'b11001, 32'h0000_0123, 32'h0000_0456, 5'd21, 0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_rd_data", 64'(rd_data), 64'd0);
      chk("mid_rst_out_tag", 64'(out_tag), 64'd0);
      chk("mid_rst_illegal", 64'(illegal_op), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(5'b00000, 32'h0000_0100, 32'h0000_0023, 5'd22, 1);

      // Randomised traffic with a randomly stalling consumer
      rdy_mode = 2;
      for (int i = 0; i < 300; i++)
         send(5'($urandom_range(0, 31)), rand_opnd(), rand_opnd(), 5'($urandom), 1);

      rdy_mode = 0;
      n = 0;
      while (q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
      chk("drain", 64'(q.size()), 64'd0);
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
